// File: rtl/sync_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sync_frame_tx
//  Description : Serial frame transmitter. Each accepted payload is sent as
//                a 4-bit sync word followed by the payload, both MSB first.
//                A 0 is stuffed after any payload bit that completes the
//                pattern 101, so 1011 cannot reappear after the sync word.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_frame_tx #(
  parameter logic [3:0] SYNC_WORD = 4'b1011,
  parameter int         PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 in_ready,
  output logic                 data,
  output logic                 data_en,
  output logic                 busy,
  output logic                 done
);

  // Counter holds 0..PAYLOAD_W so it reaches the last bit without wrapping.
  localparam int                 c_CNT_W     = $clog2(PAYLOAD_W + 1);
  localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(PAYLOAD_W);
  localparam logic [2:0]         c_STUFF_PAT = 3'b101;

  // The state names the kind of bit currently on the line (IDLE = none).
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SYNC    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_STUFF   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state;
  logic [PAYLOAD_W-1:0]   r_shift;
  logic [PAYLOAD_W-1:0]   w_shift;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_cnt;
  logic [1:0]             r_sync_idx;
  logic [1:0]             w_sync_idx;
  logic [2:0]             r_hist;
  logic [2:0]             w_hist;
  logic                   r_data;
  logic                   w_data;
  logic                   r_data_en;
  logic                   w_data_en;
  logic                   r_done;
  logic                   w_done;

  // Flow control is a pure decode of the state register.
  assign in_ready = (r_state == S_IDLE);
  assign busy     = ~in_ready;
  assign data     = r_data;
  assign data_en  = r_data_en;
  assign done     = r_done;

  // Next-state and next-output decode; outputs are the bit for the next cycle.
  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_cnt      = r_cnt;
    w_sync_idx = r_sync_idx;
    w_data     = 1'b0;
    w_data_en  = 1'b0;
    w_done     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state    = S_SYNC;
          w_shift    = in_data;
          w_cnt      = '0;
          w_sync_idx = 2'd0;
          w_data     = SYNC_WORD[3];
          w_data_en  = 1'b1;
        end
      end
      S_SYNC: begin
        w_data_en = 1'b1;
        if (r_sync_idx == 2'd3) begin
          w_state = S_PAYLOAD;
          w_data  = r_shift[PAYLOAD_W-1];
          w_shift = r_shift << 1;
          w_cnt   = r_cnt + c_CNT_W'(1);
        end else begin
          w_sync_idx = r_sync_idx + 2'd1;
          w_data     = SYNC_WORD[2'd2 - r_sync_idx];
        end
      end
      S_PAYLOAD, S_STUFF: begin
        // History already includes the bit on the line this cycle.
        if ((r_state == S_PAYLOAD) && (r_hist == c_STUFF_PAT)) begin
          w_state   = S_STUFF;
          w_data    = 1'b0;
          w_data_en = 1'b1;
        end else if (r_cnt == c_LAST) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
        end else begin
          w_state   = S_PAYLOAD;
          w_data    = r_shift[PAYLOAD_W-1];
          w_data_en = 1'b1;
          w_shift   = r_shift << 1;
          w_cnt     = r_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Every emitted line bit, sync or payload or stuff, enters the history.
    w_hist = w_data_en ? {r_hist[1:0], w_data} : r_hist;
  end

  // State, datapath and registered outputs; reset overrides any accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_sync_idx <= 2'd0;
      r_hist     <= 3'b000;
      r_data     <= 1'b0;
      r_data_en  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_cnt      <= w_cnt;
      r_sync_idx <= w_sync_idx;
      r_hist     <= w_hist;
      r_data     <= w_data;
      r_data_en  <= w_data_en;
      r_done     <= w_done;
    end
  end

endmodule
`default_nettype wire
